// File: rtl/rf_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_buffer
//  Description : In-order queue of pending (register id, data) results that
//                feeds the single write port of the 16x16 register file, with
//                two combinational lookup ports that forward queued values
//                not yet written to the RF.
//  Ports       : clk                          rising-edge clock
//                rst                          asynchronous reset, active-low
//                in_valid/in_ready            producer push handshake
//                in_reg/in_data               pushed register id / data
//                drain_en                     RF write port free this cycle
//                WriteReg/DstReg/DstData      RF write enable / id / data
//                LkReg1/LkHit1/LkData1        lookup port 1
//                LkReg2/LkHit2/LkData2        lookup port 2
//                count                        occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module rf_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     WriteReg,
  output logic [AW-1:0]            DstReg,
  output logic [DW-1:0]            DstData,
  input  logic [AW-1:0]            LkReg1,
  output logic                     LkHit1,
  output logic [DW-1:0]            LkData1,
  input  logic [AW-1:0]            LkReg2,
  output logic                     LkHit2,
  output logic [DW-1:0]            LkData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0] r_reg  [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic w_nonempty;
  logic w_push;
  logic w_pop;
  logic [PW-1:0] w_idx;

  assign w_nonempty = (r_count != '0);
  assign WriteReg   = w_nonempty & drain_en;
  assign w_pop      = WriteReg;
  // When full, a retiring head frees a slot in the same cycle, so a push is
  // still accepted while drain_en is high.
  assign in_ready   = (r_count < c_DEPTH) | drain_en;
  assign w_push     = in_valid & in_ready;
  assign DstReg     = w_nonempty ? r_reg[r_head]  : '0;
  assign DstData    = w_nonempty ? r_data[r_head] : '0;
  assign count      = r_count;

  // Walk the queue from oldest to youngest so a later match overrides an
  // earlier one; the youngest entry for a register therefore wins. The
  // current cycle's push is not yet stored and so is never searched.
  always_comb begin
    LkHit1  = 1'b0;
    LkData1 = '0;
    LkHit2  = 1'b0;
    LkData2 = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + k[PW-1:0];
      if (r_vld[w_idx] && (r_reg[w_idx] == LkReg1)) begin
        LkHit1  = 1'b1;
        LkData1 = r_data[w_idx];
      end
      if (r_vld[w_idx] && (r_reg[w_idx] == LkReg2)) begin
        LkHit2  = 1'b1;
        LkData2 = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Retire first, then store: when full, head == tail and the new entry
      // must leave its valid bit set in the slot just vacated.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_reg[r_tail]  <= in_reg;
        r_data[r_tail] <= in_data;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback_buffer
//  Description : Directed self-checking bench for rf_writeback_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_writeback_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [3:0]  LkReg1;
  logic        LkHit1;
  logic [15:0] LkData1;
  logic [3:0]  LkReg2;
  logic        LkHit2;
  logic [15:0] LkData2;
  logic [2:0]  count;

  int n_cmp;
  int n_fail;

  rf_writeback_buffer #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_reg   (in_reg),
    .in_data  (in_data),
    .drain_en (drain_en),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .LkReg1   (LkReg1),
    .LkHit1   (LkHit1),
    .LkData1  (LkData1),
    .LkReg2   (LkReg2),
    .LkHit2   (LkHit2),
    .LkData2  (LkData2),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    drain_en = 1'b0;
    LkReg1   = '0;
    LkReg2   = '0;

    // Reset state
    #2;
    chk("rst_writereg", WriteReg, 0);
    chk("rst_count",    count,    0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dstreg",   DstReg,   0);
    chk("rst_dstdata",  DstData,  0);
    chk("rst_lkhit1",   LkHit1,   0);
    chk("rst_lkdata2",  LkData2,  0);
    tick();
    tick();
    rst = 1'b1;

    // Test 1: single push, held by drain_en=0
    tick();
    in_valid = 1'b1; in_reg = 4'd3; in_data = 16'h1234; LkReg1 = 4'd3;
    #1;
    chk("t1_no_passthru_hit", LkHit1,  0);
    chk("t1_in_ready",        in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_count",    count,    1);
    chk("t1_writereg", WriteReg, 0);
    chk("t1_dstreg",   DstReg,   3);
    chk("t1_dstdata",  DstData,  16'h1234);
    chk("t1_lkhit1",   LkHit1,   1);
    chk("t1_lkdata1",  LkData1,  16'h1234);

    // Test 2: youngest match wins
    in_valid = 1'b1; in_reg = 4'd5; in_data = 16'hAAAA;
    tick();
    in_data = 16'hBBBB;
    tick();
    in_valid = 1'b0; LkReg2 = 4'd5;
    #1;
    chk("t2_count",   count,   3);
    chk("t2_lkhit2",  LkHit2,  1);
    chk("t2_lkdata2", LkData2, 16'hBBBB);
    chk("t2_head_lk", LkData1, 16'h1234);
    LkReg2 = 4'd6;
    #1;
    chk("t2_miss_hit",  LkHit2,  0);
    chk("t2_miss_data", LkData2, 0);

    // Test 3: fill, drop when full, pop+push when full
    in_valid = 1'b1; in_reg = 4'd7; in_data = 16'h0707;
    tick();
    in_reg = 4'd8; in_data = 16'h0808; LkReg1 = 4'd8;
    #1;
    chk("t3_full_count", count,    4);
    chk("t3_full_ready", in_ready, 0);
    tick();
    #1;
    chk("t3_drop_count", count,  4);
    chk("t3_drop_lk",    LkHit1, 0);
    drain_en = 1'b1; in_reg = 4'd9; in_data = 16'h0909; LkReg1 = 4'd9;
    #1;
    chk("t3_pp_ready",    in_ready, 1);
    chk("t3_pp_writereg", WriteReg, 1);
    chk("t3_pp_dstreg",   DstReg,   3);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t3_pp_count",   count,   4);
    chk("t3_pp_head",    DstReg,  5);
    chk("t3_pp_headd",   DstData, 16'hAAAA);
    chk("t3_pp_lkdata",  LkData1, 16'h0909);
    tick();
    chk("t3_d1_data",  DstData, 16'hBBBB);
    tick();
    chk("t3_d2_reg",   DstReg,  7);
    tick();
    chk("t3_d3_reg",   DstReg,  9);
    chk("t3_d3_count", count,   1);
    tick();
    chk("t3_empty_count", count,    0);
    chk("t3_empty_wr",    WriteReg, 0);
    chk("t3_empty_dreg",  DstReg,   0);
    chk("t3_empty_ddata", DstData,  0);

    // Test 6: empty, drain_en=1, one push -> write next cycle
    in_valid = 1'b1; in_reg = 4'd2; in_data = 16'h7777;
    #1;
    chk("t6_wr_same_cycle", WriteReg, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_wr",      WriteReg, 1);
    chk("t6_dstreg",  DstReg,   2);
    chk("t6_dstdata", DstData,  16'h7777);
    tick();
    chk("t6_count_after", count, 0);

    // Test 4: streaming R1..R6 through the queue with pointer wrap
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_reg   = 4'(i);
      in_data  = 16'(i * 16'h0011);
      tick();
      chk("t4_wr",      WriteReg, 1);
      chk("t4_dstreg",  DstReg,   32'(i));
      chk("t4_dstdata", DstData,  32'(i * 16'h0011));
      chk("t4_count",   count,    1);
    end
    in_valid = 1'b0;
    tick();
    chk("t4_final_count", count, 0);

    // Test 5: asynchronous reset mid-cycle with 3 entries queued
    drain_en = 1'b0;
    in_valid = 1'b1;
    in_reg = 4'd10; in_data = 16'h000A;
    tick();
    in_reg = 4'd11; in_data = 16'h000B;
    tick();
    in_reg = 4'd12; in_data = 16'h000C;
    tick();
    in_valid = 1'b0; LkReg1 = 4'd10; LkReg2 = 4'd12;
    #1;
    chk("t5_pre_count", count,  3);
    chk("t5_pre_hit",   LkHit1, 1);
    #1;
    rst = 1'b0; drain_en = 1'b1;
    #1;
    chk("t5_rst_wr",    WriteReg, 0);
    chk("t5_rst_count", count,    0);
    chk("t5_rst_hit1",  LkHit1,   0);
    chk("t5_rst_hit2",  LkHit2,   0);
    tick();
    rst = 1'b1; drain_en = 1'b0;
    in_valid = 1'b1; in_reg = 4'd9; in_data = 16'h0F0F;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_count",   count,   1);
    chk("t5_dstreg",  DstReg,  9);
    chk("t5_dstdata", DstData, 16'h0F0F);
    chk("t5_stale",   LkHit1,  0);
    drain_en = 1'b1;
    #1;
    chk("t5_wr", WriteReg, 1);
    tick();
    chk("t5_final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
